apr_event_ctl: RTL and testbench

- Parametrised successor to the EBOX APR error/interrupt flag logic: NCHAN event channels, each with a sticky flag and an interrupt-enable bit, set/cleared by CONO-style select strobes plus a channel mask.
- Adds per-channel level/edge capture, a programmable PI assignment, and a priority-encoded request/acknowledge handshake toward PI, with optional hardware auto-clear on acknowledge.
- Sits between the MBOX/EBOX error sources and PI; its CONI image drives the EBUS read mux.

---
 rtl/apr_event_ctl.sv | 215 +++++++++++++++++++++
 tb/tb_apr_event_ctl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apr_event_ctl.sv
// APR event flag / interrupt controller: sticky per-channel flags, enables, PI assignment and a PI request handshake.
// Optional build macro APR_EVT_COUNT_EN adds per-channel saturating hit counters with a registered read port.
module apr_event_ctl #(
    parameter int               NCHAN        = 8,
    parameter int               PIA_W        = 3,
    parameter logic [NCHAN-1:0] EDGE_MASK    = 8'h80,
    parameter logic [NCHAN-1:0] AUTOCLR_MASK = 8'h00
) (
    input  logic             clk,
    input  logic             RESET_n,
    input  logic [NCHAN-1:0] evt_in,
    input  logic             sel_set,
    input  logic             sel_clr,
    input  logic             sel_en,
    input  logic             sel_dis,
    input  logic             load_pia,
    input  logic [NCHAN-1:0] mask,
    input  logic [PIA_W-1:0] pia_in,
    input  logic             irq_ack,
`ifdef APR_EVT_COUNT_EN
    input  logic [3:0]       cnt_sel,
    output logic [7:0]       cnt_q,
`endif
    output logic [NCHAN-1:0] flags,
    output logic [NCHAN-1:0] int_en,
    output logic [PIA_W-1:0] pia,
    output logic             irq_req,
    output logic [3:0]       irq_chan,
    output logic             irq_pend
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t           state_r;
    logic [NCHAN-1:0] evt_q_r;
    logic [NCHAN-1:0] flags_r;
    logic [NCHAN-1:0] int_en_r;
    logic [PIA_W-1:0] pia_r;
    logic             irq_req_r;
    logic [3:0]       irq_chan_r;

    logic [NCHAN-1:0] hit_s;
    logic [NCHAN-1:0] set_s;
    logic [NCHAN-1:0] clr_s;
    logic [NCHAN-1:0] en_s;
    logic [NCHAN-1:0] dis_s;
    logic [NCHAN-1:0] both_s;
    logic [NCHAN-1:0] pend_s;
    logic [NCHAN-1:0] chan_oh_s;
    logic [NCHAN-1:0] ackclr_s;
    logic             pia_live_s;
    logic             chan_pend_s;

    function automatic logic [3:0] lowest_idx(input logic [NCHAN-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign hit_s       = evt_in & ~(EDGE_MASK & evt_q_r);
    assign set_s       = {NCHAN{sel_set}} & mask;
    assign clr_s       = {NCHAN{sel_clr}} & mask;
    assign en_s        = {NCHAN{sel_en}} & mask;
    assign dis_s       = {NCHAN{sel_dis}} & mask;
    assign both_s      = en_s & dis_s;
    assign pend_s      = flags_r & int_en_r;
    assign pia_live_s  = (pia_r != '0);
    assign chan_pend_s = |(pend_s & chan_oh_s);

    // One-hot decode of the frozen request channel and the auto-clear pulse on acknowledge.
    always_comb begin
        chan_oh_s = '0;
        ackclr_s  = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (irq_chan_r == 4'(i)) begin
                chan_oh_s[i] = 1'b1;
            end else begin
                chan_oh_s[i] = 1'b0;
            end
        end
        if (state_r == ST_REQ && irq_ack) begin
            ackclr_s = chan_oh_s & AUTOCLR_MASK;
        end else begin
            ackclr_s = '0;
        end
    end

    // Edge history, sticky flags, enables and PI assignment.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            evt_q_r  <= '0;
            flags_r  <= '0;
            int_en_r <= '0;
            pia_r    <= '0;
        end else begin
            evt_q_r  <= evt_in;
            flags_r  <= hit_s | set_s | (flags_r & ~clr_s & ~ackclr_s);
            int_en_r <= (((int_en_r & ~dis_s) | en_s) & ~both_s) | (int_en_r & both_s);
            if (load_pia) begin
                pia_r <= pia_in;
            end else begin
                pia_r <= pia_r;
            end
        end
    end

    // Request/acknowledge handshake toward PI; the channel stays frozen while requesting.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state_r    <= ST_IDLE;
            irq_req_r  <= 1'b0;
            irq_chan_r <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if ((|pend_s) && pia_live_s) begin
                        state_r    <= ST_REQ;
                        irq_req_r  <= 1'b1;
                        irq_chan_r <= lowest_idx(pend_s);
                    end else begin
                        state_r   <= ST_IDLE;
                        irq_req_r <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (irq_ack) begin
                        state_r   <= ST_ACK;
                        irq_req_r <= 1'b0;
                    end else if (!chan_pend_s || !pia_live_s) begin
                        state_r   <= ST_IDLE;
                        irq_req_r <= 1'b0;
                    end else begin
                        state_r   <= ST_REQ;
                        irq_req_r <= 1'b1;
                    end
                end
                ST_ACK: begin
                    state_r   <= ST_IDLE;
                    irq_req_r <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    irq_req_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef APR_EVT_COUNT_EN
    logic [7:0] cnt_r [NCHAN];
    logic [7:0] cnt_q_r;
    logic [7:0] cnt_mux_s;

    // Saturating capture-hit counters; a software clear beats a same-cycle hit.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            for (int i = 0; i < NCHAN; i++) begin
                cnt_r[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                if (clr_s[i]) begin
                    cnt_r[i] <= 8'd0;
                end else if (hit_s[i] && cnt_r[i] != 8'hFF) begin
                    cnt_r[i] <= cnt_r[i] + 8'd1;
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    // Counter read mux; out-of-range selects read as zero.
    always_comb begin
        cnt_mux_s = 8'd0;
        for (int i = 0; i < NCHAN; i++) begin
            if (cnt_sel == 4'(i)) begin
                cnt_mux_s = cnt_r[i];
            end else begin
                cnt_mux_s = cnt_mux_s;
            end
        end
    end

    // Registered counter read port.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            cnt_q_r <= 8'd0;
        end else begin
            cnt_q_r <= cnt_mux_s;
        end
    end

    assign cnt_q = cnt_q_r;
`endif

    assign flags    = flags_r;
    assign int_en   = int_en_r;
    assign pia      = pia_r;
    assign irq_req  = irq_req_r;
    assign irq_chan = irq_chan_r;
    assign irq_pend = |pend_s;

endmodule

// File: tb/tb_apr_event_ctl.sv
// Self-checking bench for apr_event_ctl: directed scenarios plus a randomized run against a behavioural model.
module tb_apr_event_ctl;

    localparam logic [7:0] EDGE_M = 8'h80;
    localparam logic [7:0] ACLR_M = 8'h80;

    logic       clk = 1'b0;
    logic       RESET_n;
    logic [7:0] evt_in;
    logic       sel_set, sel_clr, sel_en, sel_dis, load_pia, irq_ack;
    logic [7:0] mask;
    logic [2:0] pia_in;
    logic [7:0] flags, int_en;
    logic [2:0] pia;
    logic       irq_req, irq_pend;
    logic [3:0] irq_chan;
`ifdef APR_EVT_COUNT_EN
    logic [3:0] cnt_sel;
    logic [7:0] cnt_q;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: phase 0 = idle, 1 = requesting, 2 = acknowledged.
    logic [7:0] m_flags, m_en, m_prev;
    logic [2:0] m_pia;
    int         m_phase;
    int         m_chan;

    apr_event_ctl #(.NCHAN(8), .PIA_W(3), .EDGE_MASK(EDGE_M), .AUTOCLR_MASK(ACLR_M)) dut (
        .clk(clk), .RESET_n(RESET_n), .evt_in(evt_in),
        .sel_set(sel_set), .sel_clr(sel_clr), .sel_en(sel_en), .sel_dis(sel_dis),
        .load_pia(load_pia), .mask(mask), .pia_in(pia_in), .irq_ack(irq_ack),
`ifdef APR_EVT_COUNT_EN
        .cnt_sel(cnt_sel), .cnt_q(cnt_q),
`endif
        .flags(flags), .int_en(int_en), .pia(pia),
        .irq_req(irq_req), .irq_chan(irq_chan), .irq_pend(irq_pend)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        evt_in = 8'h00; sel_set = 1'b0; sel_clr = 1'b0; sel_en = 1'b0; sel_dis = 1'b0;
        load_pia = 1'b0; irq_ack = 1'b0; mask = 8'h00; pia_in = 3'd0;
`ifdef APR_EVT_COUNT_EN
        cnt_sel = 4'd0;
`endif
    endtask

    task automatic model_reset();
        m_flags = 8'h00; m_en = 8'h00; m_prev = 8'h00; m_pia = 3'd0; m_phase = 0; m_chan = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET_n = 1'b0;
        model_reset();
        #2;
        RESET_n = 1'b1;
    endtask

    // Advance one clock: model computes its next state from the applied inputs, then outputs settle.
    task automatic step();
        logic [7:0] nf, ne, pend;
        int         np, nc, first;
        logic       hit, ackc, s, c, e, d;
        pend = m_flags & m_en;
        for (int i = 0; i < 8; i++) begin
            hit  = evt_in[i] && !(EDGE_M[i] && m_prev[i]);
            ackc = (m_phase == 1) && irq_ack && (m_chan == i) && ACLR_M[i];
            s = sel_set && mask[i];
            c = sel_clr && mask[i];
            e = sel_en && mask[i];
            d = sel_dis && mask[i];
            nf[i] = hit || s || (m_flags[i] && !c && !ackc);
            if (e && d)  ne[i] = m_en[i];
            else if (e)  ne[i] = 1'b1;
            else if (d)  ne[i] = 1'b0;
            else         ne[i] = m_en[i];
        end
        first = -1;
        for (int i = 0; i < 8; i++) if (first < 0 && pend[i]) first = i;
        np = m_phase; nc = m_chan;
        if (m_phase == 0) begin
            if (first >= 0 && m_pia != 3'd0) begin np = 1; nc = first; end
        end else if (m_phase == 1) begin
            if (irq_ack) np = 2;
            else if (!pend[m_chan] || m_pia == 3'd0) np = 0;
        end else begin
            np = 0;
        end
        m_flags = nf; m_en = ne; m_prev = evt_in;
        if (load_pia) m_pia = pia_in;
        m_phase = np; m_chan = nc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        RESET_n = 1'b0;
        model_reset();
        #2;
        n_checks++;
        if ({flags, int_en, pia, irq_req, irq_chan} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 0", {flags, int_en, pia, irq_req, irq_chan});
        end
        RESET_n = 1'b1;
        @(posedge clk); #1;
        // Reset arrives while channel 2 is being requested.
        mask = 8'h04; sel_set = 1'b1; sel_en = 1'b1; load_pia = 1'b1; pia_in = 3'd3;
        step();
        idle_inputs();
        step();
        n_checks++;
        if (irq_req !== 1'b1 || irq_chan !== 4'd2) begin
            n_fail++;
            $display("FAIL reset_setup_req: got req=%b chan=%0d expected req=1 chan=2", irq_req, irq_chan);
        end
        RESET_n = 1'b0;
        #1;
        n_checks++;
        if ({irq_req, flags, int_en, pia} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_mid_req: got req=%b flags=%h en=%h pia=%0d expected all 0",
                     irq_req, flags, int_en, pia);
        end
        do_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_level_irq();
        do_reset();
        @(posedge clk); #1;
        mask = 8'h01; sel_en = 1'b1; load_pia = 1'b1; pia_in = 3'd5;
        step();
        idle_inputs();
        evt_in = 8'h01;
        step();
        evt_in = 8'h00;
        n_checks++;
        if (flags[0] !== 1'b1 || irq_req !== 1'b0) begin
            n_fail++;
            $display("FAIL level_flag: got flag0=%b req=%b expected flag0=1 req=0", flags[0], irq_req);
        end
        step();
        n_checks++;
        if (irq_req !== 1'b1 || irq_chan !== 4'd0) begin
            n_fail++;
            $display("FAIL level_req: got req=%b chan=%0d expected req=1 chan=0", irq_req, irq_chan);
        end
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        n_checks++;
        if (irq_req !== 1'b0 || flags[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL level_ack: got req=%b flag0=%b expected req=0 flag0=1", irq_req, flags[0]);
        end
        step();
        n_checks++;
        if (irq_req !== 1'b0 || flags[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL level_idle: got req=%b flag0=%b expected req=0 flag0=1", irq_req, flags[0]);
        end
    endtask

    task automatic test_priority();
        do_reset();
        @(posedge clk); #1;
        mask = 8'h28; sel_set = 1'b1; sel_en = 1'b1; load_pia = 1'b1; pia_in = 3'd1;
        step();
        idle_inputs();
        step();
        n_checks++;
        if (irq_req !== 1'b1 || irq_chan !== 4'd3) begin
            n_fail++;
            $display("FAIL prio_first: got req=%b chan=%0d expected req=1 chan=3", irq_req, irq_chan);
        end
        mask = 8'h02; sel_set = 1'b1; sel_en = 1'b1;
        step();
        idle_inputs();
        n_checks++;
        if (irq_req !== 1'b1 || irq_chan !== 4'd3) begin
            n_fail++;
            $display("FAIL prio_no_preempt: got req=%b chan=%0d expected req=1 chan=3", irq_req, irq_chan);
        end
        irq_ack = 1'b1;
        step();
        idle_inputs();
        mask = 8'h08; sel_clr = 1'b1;
        step();
        idle_inputs();
        step();
        n_checks++;
        if (irq_req !== 1'b1 || irq_chan !== 4'd1) begin
            n_fail++;
            $display("FAIL prio_next: got req=%b chan=%0d expected req=1 chan=1", irq_req, irq_chan);
        end
    endtask

    task automatic test_collisions();
        do_reset();
        @(posedge clk); #1;
        mask = 8'h01; sel_clr = 1'b1; evt_in = 8'h01;
        step();
        idle_inputs();
        n_checks++;
        if (flags[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_vs_hit: got flag0=%b expected 1", flags[0]);
        end
        mask = 8'h04; sel_en = 1'b1;
        step();
        sel_dis = 1'b1;
        step();
        n_checks++;
        if (int_en[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL en_dis_hold1: got en2=%b expected 1", int_en[2]);
        end
        sel_en = 1'b0;
        step();
        sel_en = 1'b1;
        step();
        idle_inputs();
        n_checks++;
        if (int_en[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL en_dis_hold0: got en2=%b expected 0", int_en[2]);
        end
    endtask

    task automatic test_edge_autoclr();
        do_reset();
        @(posedge clk); #1;
        mask = 8'h80; sel_en = 1'b1; load_pia = 1'b1; pia_in = 3'd2;
        step();
        idle_inputs();
        evt_in = 8'h80;
        step();
        step();
        n_checks++;
        if (flags[7] !== 1'b1 || irq_req !== 1'b1 || irq_chan !== 4'd7) begin
            n_fail++;
            $display("FAIL edge_req: got flag7=%b req=%b chan=%0d expected 1 1 7", flags[7], irq_req, irq_chan);
        end
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        n_checks++;
        if (flags[7] !== 1'b0) begin
            n_fail++;
            $display("FAIL autoclr: got flag7=%b expected 0", flags[7]);
        end
        for (int k = 0; k < 7; k++) begin
            step();
            n_checks++;
            if (flags[7] !== 1'b0 || irq_req !== 1'b0) begin
                n_fail++;
                $display("FAIL edge_once cyc%0d: got flag7=%b req=%b expected 0 0", k, flags[7], irq_req);
            end
        end
        idle_inputs();
    endtask

    task automatic test_withdraw();
        do_reset();
        @(posedge clk); #1;
        mask = 8'h02; sel_set = 1'b1; sel_en = 1'b1; load_pia = 1'b1; pia_in = 3'd4;
        step();
        idle_inputs();
        step();
        load_pia = 1'b1; pia_in = 3'd0;
        step();
        load_pia = 1'b0;
        n_checks++;
        if (pia !== 3'd0 || irq_req !== 1'b1) begin
            n_fail++;
            $display("FAIL withdraw_load: got pia=%0d req=%b expected pia=0 req=1", pia, irq_req);
        end
        step();
        n_checks++;
        if (irq_req !== 1'b0 || irq_pend !== 1'b1) begin
            n_fail++;
            $display("FAIL withdraw_idle: got req=%b pend=%b expected req=0 pend=1", irq_req, irq_pend);
        end
        step();
        n_checks++;
        if (irq_req !== 1'b0) begin
            n_fail++;
            $display("FAIL pia0_blocks: got req=%b expected 0", irq_req);
        end
`ifdef APR_EVT_COUNT_EN
        evt_in = 8'h10;
        for (int k = 0; k < 300; k++) step();
        evt_in = 8'h00; cnt_sel = 4'd4;
        step();
        step();
        n_checks++;
        if (cnt_q !== 8'hFF) begin
            n_fail++;
            $display("FAIL cnt_sat: got %h expected ff", cnt_q);
        end
        mask = 8'h10; sel_clr = 1'b1;
        step();
        idle_inputs(); cnt_sel = 4'd4;
        step();
        n_checks++;
        if (cnt_q !== 8'h00) begin
            n_fail++;
            $display("FAIL cnt_clr: got %h expected 00", cnt_q);
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        @(posedge clk); #1;
        for (int k = 0; k < 500; k++) begin
            evt_in   = 8'($urandom) & 8'($urandom) & 8'($urandom);
            mask     = 8'($urandom);
            sel_set  = ($urandom_range(0, 7) == 0);
            sel_clr  = ($urandom_range(0, 3) == 0);
            sel_en   = ($urandom_range(0, 3) == 0);
            sel_dis  = ($urandom_range(0, 7) == 0);
            load_pia = ($urandom_range(0, 7) == 0);
            pia_in   = 3'($urandom);
            irq_ack  = ($urandom_range(0, 2) == 0);
            step();
            n_checks++;
            if ({flags, int_en, pia, irq_req, irq_chan, irq_pend} !==
                {m_flags, m_en, m_pia, (m_phase == 1), 4'(m_chan), |(m_flags & m_en)}) begin
                n_fail++;
                $display("FAIL random cyc%0d: got fl=%h en=%h pia=%0d req=%b ch=%0d pend=%b expected fl=%h en=%h pia=%0d req=%b ch=%0d pend=%b",
                         k, flags, int_en, pia, irq_req, irq_chan, irq_pend,
                         m_flags, m_en, m_pia, (m_phase == 1), m_chan, |(m_flags & m_en));
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_level_irq();
        test_priority();
        test_collisions();
        test_edge_autoclr();
        test_withdraw();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
